// File: rtl/alu8b_sequencer.sv
// Command sequencer feeding alu8b: buffers commands in a FIFO, drives the ALU from the
// FIFO head and captures results into a valid/ready response register, with chain mode.
`timescale 1ns/1ps

module alu8b_sequencer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     Clk_in,
    input  logic                     Rst_in,
    input  logic                     Cmd_valid_in,
    output logic                     Cmd_ready_out,
    input  logic [2:0]               Cmd_opcode_in,
    input  logic [7:0]               Cmd_a_in,
    input  logic [7:0]               Cmd_b_in,
    input  logic                     Cmd_cin_in,
    input  logic                     Cmd_chain_in,
    output logic [7:0]               Alu_a_out,
    output logic [7:0]               Alu_b_out,
    output logic                     Alu_cin_out,
    output logic [2:0]               Alu_opcode_out,
    input  logic [7:0]               Alu_result_in,
    input  logic                     Alu_cout_in,
    output logic                     Rsp_valid_out,
    input  logic                     Rsp_ready_in,
    output logic [7:0]               Rsp_result_out,
    output logic                     Rsp_cout_out,
    output logic [$clog2(DEPTH):0]   Fifo_count_out
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0]   DepthCnt = (PtrW + 1)'(DEPTH);
    localparam logic [PtrW:0]   CntOne   = (PtrW + 1)'(1);
    localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);

    typedef struct packed {
        logic [2:0] opcode;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       chain;
    } cmd_t;

    cmd_t            fifo_q [DEPTH];
    cmd_t            cmd_in;
    cmd_t            head;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [7:0]      rsp_result_q, rsp_result_d;
    logic            rsp_cout_q, rsp_cout_d;
    logic [7:0]      acc_q, acc_d;
    logic            carry_q, carry_d;
    logic            empty;
    logic            push;
    logic            issue;

    assign cmd_in = '{opcode: Cmd_opcode_in, a: Cmd_a_in, b: Cmd_b_in,
                      cin: Cmd_cin_in, chain: Cmd_chain_in};
    assign head   = fifo_q[rd_ptr_q];
    assign empty  = (count_q == '0);

    // Ready depends on registered count only, so a full FIFO refuses even on a same-cycle pop.
    assign Cmd_ready_out = (count_q < DepthCnt);
    assign push          = Cmd_valid_in && Cmd_ready_out;
    assign issue         = !empty && (!rsp_valid_q || Rsp_ready_in);

    always_comb begin
        Alu_a_out      = '0;
        Alu_b_out      = '0;
        Alu_cin_out    = 1'b0;
        Alu_opcode_out = '0;
        if (!empty) begin
            Alu_a_out      = head.chain ? acc_q : head.a;
            Alu_cin_out    = head.chain ? carry_q : head.cin;
            Alu_b_out      = head.b;
            Alu_opcode_out = head.opcode;
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_cout_d   = rsp_cout_q;
        acc_d        = acc_q;
        carry_d      = carry_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (issue) begin
            rd_ptr_d     = rd_ptr_q + PtrOne;
            rsp_valid_d  = 1'b1;
            rsp_result_d = Alu_result_in;
            rsp_cout_d   = Alu_cout_in;
            acc_d        = Alu_result_in;
            carry_d      = Alu_cout_in;
        end else if (rsp_valid_q && Rsp_ready_in) begin
            rsp_valid_d = 1'b0;
        end

        unique case ({push, issue})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk_in or posedge Rst_in) begin
        if (Rst_in) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_cout_q   <= 1'b0;
            acc_q        <= '0;
            carry_q      <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_cout_q   <= rsp_cout_d;
            acc_q        <= acc_d;
            carry_q      <= carry_d;
        end
    end

    // Storage needs no reset: entries are only read while count says they are live.
    always_ff @(posedge Clk_in) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= cmd_in;
        end
    end

    assign Rsp_valid_out  = rsp_valid_q;
    assign Rsp_result_out = rsp_result_q;
    assign Rsp_cout_out   = rsp_cout_q;
    assign Fifo_count_out = count_q;

endmodule

// File: tb/tb_alu8b_sequencer.sv
// Self-checking bench for alu8b_sequencer: directed scenarios plus randomized traffic
// compared against a queue-based transaction model; an alu8b model closes the loop.
`timescale 1ns/1ps

module tb_alu8b_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int CntW = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [2:0]      cmd_op = '0;
    logic [7:0]      cmd_a = '0;
    logic [7:0]      cmd_b = '0;
    logic            cmd_cin = 1'b0;
    logic            cmd_chain = 1'b0;
    logic [7:0]      alu_a, alu_b;
    logic            alu_cin;
    logic [2:0]      alu_op;
    logic [7:0]      alu_result;
    logic            alu_cout;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [7:0]      rsp_result;
    logic            rsp_cout;
    logic [CntW-1:0] fifo_count;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       chain;
    } mcmd_t;

    mcmd_t      m_q[$];
    logic       m_rsp_valid;
    logic [7:0] m_rsp_res;
    logic       m_rsp_cout;
    logic [7:0] m_acc;
    logic       m_carry;

    alu8b_sequencer #(.DEPTH(DEPTH)) dut (
        .Clk_in        (clk),
        .Rst_in        (rst),
        .Cmd_valid_in  (cmd_valid),
        .Cmd_ready_out (cmd_ready),
        .Cmd_opcode_in (cmd_op),
        .Cmd_a_in      (cmd_a),
        .Cmd_b_in      (cmd_b),
        .Cmd_cin_in    (cmd_cin),
        .Cmd_chain_in  (cmd_chain),
        .Alu_a_out     (alu_a),
        .Alu_b_out     (alu_b),
        .Alu_cin_out   (alu_cin),
        .Alu_opcode_out(alu_op),
        .Alu_result_in (alu_result),
        .Alu_cout_in   (alu_cout),
        .Rsp_valid_out (rsp_valid),
        .Rsp_ready_in  (rsp_ready),
        .Rsp_result_out(rsp_result),
        .Rsp_cout_out  (rsp_cout),
        .Fifo_count_out(fifo_count)
    );

    always #5 clk = ~clk;

    // Returns {cout, result}; opcodes 101-111 yield 0/0.
    function automatic logic [8:0] ref_alu(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic cin);
        logic [8:0] r;
        r = '0;
        case (op)
            3'b000:  r = {1'b0, a} + {1'b0, b} + {8'b0, cin};
            3'b001:  r = {1'b0, a} - {1'b0, b} - {8'b0, cin};
            3'b010:  r = {1'b0, a & b};
            3'b011:  r = {1'b0, a | b};
            3'b100:  r = (b == 8'd0) ? 9'd0 : {1'b0, a % b};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        {alu_cout, alu_result} = ref_alu(alu_op, alu_a, alu_b, alu_cin);
    end

    task automatic model_reset();
        m_q.delete();
        m_rsp_valid = 1'b0;
        m_rsp_res   = '0;
        m_rsp_cout  = 1'b0;
        m_acc       = '0;
        m_carry     = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic cin, input logic chain);
        cmd_valid = v;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_cin   = cin;
        cmd_chain = chain;
    endtask

    // Advances one clock and applies the transaction-level effect of that edge to the model.
    task automatic cycle();
        bit         push, issue;
        mcmd_t      c;
        logic [7:0] a;
        logic       cin;
        logic [8:0] r;
        push  = cmd_valid && (m_q.size() < DEPTH);
        issue = (m_q.size() != 0) && (!m_rsp_valid || rsp_ready);
        @(posedge clk);
        #1;
        if (issue) begin
            c   = m_q.pop_front();
            a   = c.chain ? m_acc : c.a;
            cin = c.chain ? m_carry : c.cin;
            r   = ref_alu(c.op, a, c.b, cin);
            m_rsp_valid = 1'b1;
            m_rsp_res   = r[7:0];
            m_rsp_cout  = r[8];
            m_acc       = r[7:0];
            m_carry     = r[8];
        end else if (m_rsp_valid && rsp_ready) begin
            m_rsp_valid = 1'b0;
        end
        if (push) begin
            c.op = cmd_op; c.a = cmd_a; c.b = cmd_b; c.cin = cmd_cin; c.chain = cmd_chain;
            m_q.push_back(c);
        end
    endtask

    task automatic idle(input int n);
        drive(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        rsp_ready = 1'b1;
        repeat (n) cycle();
    endtask

    task automatic test_reset();
        rsp_ready = 1'b0;
        drive(1'b1, 3'b000, 8'h11, 8'h22, 1'b0, 1'b0);
        cycle();
        cycle();
        drive(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        checks++;
        if (fifo_count !== CntW'(1) || rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre: count=%0d valid=%0b required count=1 valid=1",
                     fifo_count, rsp_valid);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (fifo_count !== '0) begin
            failures++;
            $display("FAIL reset_count: got %0d required 0", fifo_count);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %0b required 1", cmd_ready);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_result !== 8'h00 || rsp_cout !== 1'b0) begin
            failures++;
            $display("FAIL reset_rsp: got valid=%0b res=%h cout=%0b required 0/00/0",
                     rsp_valid, rsp_result, rsp_cout);
        end
        checks++;
        if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_cin !== 1'b0 || alu_op !== 3'b000) begin
            failures++;
            $display("FAIL reset_alu: got a=%h b=%h cin=%0b op=%0d required all 0",
                     alu_a, alu_b, alu_cin, alu_op);
        end
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single_add();
        rsp_ready = 1'b1;
        drive(1'b1, 3'b000, 8'hAA, 8'h02, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        checks++;
        if (rsp_valid !== 1'b0 || alu_a !== 8'hAA || alu_b !== 8'h02) begin
            failures++;
            $display("FAIL add_accept: got valid=%0b a=%h b=%h required 0/AA/02",
                     rsp_valid, alu_a, alu_b);
        end
        cycle();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 8'hAC || rsp_cout !== 1'b0) begin
            failures++;
            $display("FAIL add_rsp: got valid=%0b res=%h cout=%0b required 1/AC/0",
                     rsp_valid, rsp_result, rsp_cout);
        end
        cycle();
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL add_drain: got valid=%0b required 0", rsp_valid);
        end
        idle(1);
    endtask

    task automatic test_chain();
        rsp_ready = 1'b1;
        drive(1'b1, 3'b000, 8'hFE, 8'h01, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 3'b000, 8'h55, 8'h00, 1'b0, 1'b1);
        cycle();
        drive(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 8'h00 || rsp_cout !== 1'b1) begin
            failures++;
            $display("FAIL chain_first: got valid=%0b res=%h cout=%0b required 1/00/1",
                     rsp_valid, rsp_result, rsp_cout);
        end
        checks++;
        if (alu_a !== 8'h00 || alu_cin !== 1'b1) begin
            failures++;
            $display("FAIL chain_drive: got a=%h cin=%0b required 00/1", alu_a, alu_cin);
        end
        cycle();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 8'h01 || rsp_cout !== 1'b0) begin
            failures++;
            $display("FAIL chain_second: got valid=%0b res=%h cout=%0b required 1/01/0",
                     rsp_valid, rsp_result, rsp_cout);
        end
        idle(2);
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_res [5];
        exp_res[0] = 8'h00; exp_res[1] = 8'hFF; exp_res[2] = 8'h01;
        exp_res[3] = 8'hFE; exp_res[4] = 8'h00;
        rsp_ready = 1'b0;
        drive(1'b1, 3'b010, 8'hAA, 8'h55, 1'b0, 1'b0); cycle();
        drive(1'b1, 3'b011, 8'hAA, 8'h55, 1'b0, 1'b0); cycle();
        drive(1'b1, 3'b100, 8'h0A, 8'h03, 1'b0, 1'b0); cycle();
        drive(1'b1, 3'b001, 8'hFF, 8'h01, 1'b0, 1'b0); cycle();
        drive(1'b1, 3'b101, 8'h12, 8'h34, 1'b1, 1'b0); cycle();
        checks++;
        if (cmd_ready !== 1'b0 || fifo_count !== CntW'(4)) begin
            failures++;
            $display("FAIL bp_full: got ready=%0b count=%0d required 0/4", cmd_ready, fifo_count);
        end
        drive(1'b1, 3'b000, 8'h01, 8'h01, 1'b0, 1'b0); cycle();
        drive(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        checks++;
        if (fifo_count !== CntW'(4) || rsp_result !== 8'h00 || rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_refuse: got count=%0d valid=%0b res=%h required 4/1/00",
                     fifo_count, rsp_valid, rsp_result);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== exp_res[i] || rsp_cout !== 1'b0) begin
                failures++;
                $display("FAIL bp_rsp%0d: got valid=%0b res=%h cout=%0b required 1/%h/0",
                         i, rsp_valid, rsp_result, rsp_cout, exp_res[i]);
            end
            rsp_ready = 1'b1;
            cycle();
            if (i == 0) begin
                checks++;
                if (cmd_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_ready_back: got %0b required 1", cmd_ready);
                end
            end
        end
        checks++;
        if (rsp_valid !== 1'b0 || fifo_count !== '0) begin
            failures++;
            $display("FAIL bp_empty: got valid=%0b count=%0d required 0/0", rsp_valid, fifo_count);
        end
        idle(1);
    endtask

    task automatic test_streaming();
        rsp_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                drive(1'b1, 3'($urandom_range(0, 4)), 8'($urandom), 8'($urandom),
                      1'($urandom), 1'($urandom));
            end else begin
                drive(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0);
            end
            cycle();
            checks++;
            if (fifo_count > CntW'(1)) begin
                failures++;
                $display("FAIL stream_count%0d: got %0d required <=1", i, fifo_count);
            end
            if (i >= 1) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_result !== m_rsp_res || rsp_cout !== m_rsp_cout) begin
                    failures++;
                    $display("FAIL stream_rsp%0d: got valid=%0b res=%h cout=%0b required 1/%h/%0b",
                             i, rsp_valid, rsp_result, rsp_cout, m_rsp_res, m_rsp_cout);
                end
            end
        end
        idle(2);
    endtask

    task automatic test_reset_midstream();
        rsp_ready = 1'b0;
        drive(1'b1, 3'b000, 8'hFF, 8'hFF, 1'b1, 1'b0); cycle();
        drive(1'b1, 3'b011, 8'h0F, 8'hF0, 1'b0, 1'b0); cycle();
        drive(1'b1, 3'b001, 8'h00, 8'h01, 1'b0, 1'b0); cycle();
        drive(1'b1, 3'b000, 8'h80, 8'h80, 1'b0, 1'b1); cycle();
        drive(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        checks++;
        if (fifo_count !== CntW'(3) || rsp_valid !== 1'b1 || rsp_result !== 8'hFF) begin
            failures++;
            $display("FAIL mid_pre: got count=%0d valid=%0b res=%h required 3/1/FF",
                     fifo_count, rsp_valid, rsp_result);
        end
        #3 rst = 1'b1;
        #2 rst = 1'b0;
        model_reset();
        checks++;
        if (fifo_count !== '0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_flush: got count=%0d valid=%0b required 0/0", fifo_count, rsp_valid);
        end
        rsp_ready = 1'b1;
        drive(1'b1, 3'b000, 8'h77, 8'h05, 1'b1, 1'b1);
        cycle();
        drive(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        cycle();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 8'h05 || rsp_cout !== 1'b0) begin
            failures++;
            $display("FAIL mid_chain: got valid=%0b res=%h cout=%0b required 1/05/0",
                     rsp_valid, rsp_result, rsp_cout);
        end
        idle(2);
    endtask

    task automatic test_random();
        mcmd_t      h;
        logic [7:0] ea;
        logic       ecin;
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 8'($urandom),
                  8'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0));
            rsp_ready = ($urandom_range(0, 2) != 0);
            cycle();
            checks++;
            if (cmd_ready !== (m_q.size() < DEPTH) || fifo_count !== CntW'(m_q.size())) begin
                failures++;
                $display("FAIL rand_fifo%0d: got ready=%0b count=%0d required %0b/%0d",
                         i, cmd_ready, fifo_count, (m_q.size() < DEPTH), m_q.size());
            end
            checks++;
            if (rsp_valid !== m_rsp_valid || rsp_result !== m_rsp_res || rsp_cout !== m_rsp_cout) begin
                failures++;
                $display("FAIL rand_rsp%0d: got %0b/%h/%0b required %0b/%h/%0b", i, rsp_valid,
                         rsp_result, rsp_cout, m_rsp_valid, m_rsp_res, m_rsp_cout);
            end
            if (m_q.size() != 0) begin
                h    = m_q[0];
                ea   = h.chain ? m_acc : h.a;
                ecin = h.chain ? m_carry : h.cin;
            end else begin
                h    = '0;
                ea   = '0;
                ecin = 1'b0;
            end
            checks++;
            if (alu_a !== ea || alu_b !== h.b || alu_cin !== ecin || alu_op !== h.op) begin
                failures++;
                $display("FAIL rand_alu%0d: got %h/%h/%0b/%0d required %h/%h/%0b/%0d", i, alu_a,
                         alu_b, alu_cin, alu_op, ea, h.b, ecin, h.op);
            end
        end
        idle(DEPTH + 2);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_single_add();
        test_chain();
        test_backpressure();
        test_streaming();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu8b_sequencer.md
# alu8b_sequencer

Command sequencer that sits directly upstream of `alu8b` and feeds it. It buffers ALU commands in a small FIFO and drives the ALU operand, carry and opcode inputs from the FIFO head. It captures the combinational ALU result into a response register with valid/ready handshaking. A chain mode replaces operand A and the carry-in with the previous result and carry-out, so multi-byte arithmetic needs no external feedback.

## Interface
- `DEPTH`, default 4: command FIFO depth; must be a power of 2, ≥ 2.
- `Clk_in` in 1: clock; all state updates on the rising edge.
- `Rst_in` in 1: reset, asynchronous, active-high.
- `Cmd_valid_in` in 1: command present.
- `Cmd_ready_out` out 1: sequencer can accept a command.
- `Cmd_opcode_in` in 3: ALU opcode.
- `Cmd_a_in` in 8: operand A; ignored when chaining.
- `Cmd_b_in` in 8: operand B.
- `Cmd_cin_in` in 1: carry-in; ignored when chaining.
- `Cmd_chain_in` in 1: use accumulator as A and stored carry as carry-in.
- `Alu_a_out` out 8: to `alu8b` `A_in`.
- `Alu_b_out` out 8: to `alu8b` `B_in`.
- `Alu_cin_out` out 1: to `alu8b` `C_in`.
- `Alu_opcode_out` out 3: to `alu8b` `Opcode_in`.
- `Alu_result_in` in 8: from `alu8b` `Result_out`.
- `Alu_cout_in` in 1: from `alu8b` `C_out`.
- `Rsp_valid_out` out 1: response register holds a result.
- `Rsp_ready_in` in 1: consumer takes the response.
- `Rsp_result_out` out 8: captured result.
- `Rsp_cout_out` out 1: captured carry-out.
- `Fifo_count_out` out log2(DEPTH)+1: number of FIFO entries, 0..DEPTH.

## Operation
**Push**
- A push happens when `Cmd_valid_in` && `Cmd_ready_out`.
- The stored entry is {opcode, a, b, cin, chain}.

**ALU drive (combinational from the FIFO head)**
- `Alu_a_out` = chain ? Acc : a.
- `Alu_cin_out` = chain ? Carry : cin.
- `Alu_b_out` = b; `Alu_opcode_out` = opcode.
- When the FIFO is empty, all `Alu_*` outputs are 0.

**Issue**
- Issue occurs when the FIFO is non-empty and (!`Rsp_valid_out` || `Rsp_ready_in`).
- On issue, all of the following happen at the same edge:
  - the head is popped;
  - {`Rsp_result_out`, `Rsp_cout_out`} ← {`Alu_result_in`, `Alu_cout_in`};
  - `Rsp_valid_out` ← 1;
  - Acc ← `Alu_result_in`; Carry ← `Alu_cout_in`.

**Drain**
- A response is consumed when `Rsp_valid_out` && `Rsp_ready_in`.
- If there is no issue in the same cycle, `Rsp_valid_out` ← 0 and the result/cout registers hold their values.

**Other rules**
- Responses leave in command order. There is no reordering and no dropping.
- Opcodes 101–111 are passed through unmodified. The ALU returns 0/0, the response is 0/0, and Acc/Carry are updated to 0/0.
- Acc and Carry change only on issue. They are not visible on the ports except through chaining.

## Timing
**Reset values (Rst_in high, asynchronous, takes effect immediately)**
- FIFO empty; `Fifo_count_out` = 0.
- `Cmd_ready_out` = 1.
- `Rsp_valid_out` = 0, `Rsp_result_out` = 0, `Rsp_cout_out` = 0.
- Acc = 0, Carry = 0.
- All `Alu_*` outputs = 0.
- Reset during operation discards all queued commands and any pending response.

**Handshake rules**
- `Cmd_ready_out` = (count < DEPTH), derived from registered count only.
- When the FIFO is full, a push is refused even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full leaves the count unchanged.
- Read and write pointers wrap modulo DEPTH.

**Latency and throughput**
- A command accepted at edge N into an empty FIFO, with the response slot free, issues at edge N+1. `Rsp_valid_out` is high after edge N+1, giving 1 cycle of latency.
- Throughput is 1 command per cycle while `Rsp_ready_in` is held high.
- Back-to-back chained commands see the Acc/Carry written by the immediately preceding issue.

**Backpressure capacity**
- With `Rsp_ready_in` low, capacity is DEPTH + 1 commands: DEPTH in the FIFO plus one in the response register.
- Response outputs stay stable while `Rsp_valid_out` && !`Rsp_ready_in`.

## Test plan
1. **Reset.** Assert `Rst_in` mid-cycle.
   - Required: all outputs go to their reset values immediately, `Cmd_ready_out` = 1, `Fifo_count_out` = 0.
2. **Single add.** `Rsp_ready_in` = 1; push A=AA, B=02, cin=0, op=000.
   - Required: one cycle after acceptance, `Rsp_valid_out` = 1, result = AC, cout = 0.
   - Required: `Rsp_valid_out` = 0 on the following cycle.
3. **Chain.** Push FE+01, cin=1, op=000, then push chain=1, B=00, op=000 (A=55, cin=0 supplied but ignored).
   - Required: first response 00/1.
   - Required: second issue drives `Alu_a_out` = 00 and `Alu_cin_out` = 1, giving response 01/0.
4. **Backpressure.** Hold `Rsp_ready_in` = 0 and push six commands: AND AA,55; OR AA,55; MOD 0A,03; SUB FF,01; op 101; ADD 01,01.
   - Required: after five accepts `Cmd_ready_out` = 0, `Fifo_count_out` = 4, and the sixth push is refused.
   - Then raise `Rsp_ready_in`. Required: responses in order 00, FF, 01, FE, 00, all with cout = 0, and `Cmd_ready_out` returns to 1 one cycle after the first pop.
5. **Streaming.** Hold `Rsp_ready_in` = 1 and push a new command every cycle for 8 cycles.
   - Required: `Rsp_valid_out` stays high continuously, one response per cycle, `Fifo_count_out` ≤ 1.
6. **Reset mid-stream.** Fill the FIFO with 3 entries and a pending response, then pulse `Rst_in`.
   - Required: queue and response are discarded, and a subsequent chained add of 00+05 returns 05/0 (Acc and Carry cleared).
